// File: rtl/overlay_bar_sched.sv
`default_nettype none
// ============================================================================
//  Module      : overlay_bar_sched
//  Description : Per-frame audio peak scheduler and ring buffer for the bar
//                overlay; optional decaying peak marker when PEAK_HOLD_EN is
//                defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module overlay_bar_sched #(
   parameter int unsigned NBARS       = 32,
   parameter int unsigned SILENCE_TH  = 4,
   parameter int unsigned HIDE_FRAMES = 150
) (
   input  logic       clk_vid,
   input  logic       reset,
   input  logic [7:0] din,
   input  logic       sample,
   input  logic       vsync,
   input  logic [3:0] status,
   input  logic       en,
   input  logic [6:0] rd_col,
   output logic [6:0] rd_data,
   output logic       show,
   output logic       ready,
   output logic [6:0] peak_hold
);

   localparam int unsigned      c_aw       = (NBARS > 1) ? $clog2(NBARS) : 1;
   localparam logic [c_aw-1:0]  c_last_idx = c_aw'(NBARS - 1);
   localparam logic [c_aw-1:0]  c_one      = c_aw'(1);
   localparam logic [6:0]       c_sil_th   = 7'(SILENCE_TH);
   localparam logic [9:0]       c_hide     = 10'(HIDE_FRAMES);
   localparam logic [7:0]       c_nbars    = 8'(NBARS);

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_IDLE   = 2'd1,
      ST_WRITE  = 2'd2,
      ST_UPDATE = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;

   logic [6:0]      r_mem [NBARS];
   logic [6:0]      r_acc;
   logic [6:0]      r_bar;
   logic [6:0]      r_rd_data;
   logic [c_aw-1:0] r_wr_ptr;
   logic [c_aw-1:0] r_idx;
   logic [9:0]      r_sil_cnt;
   logic            r_hidden;
   logic            r_ready;
   logic            r_vsync_d;

   logic            w_tick;
   logic [7:0]      w_diff;
   logic [6:0]      w_mag;
   logic            w_mem_we;
   logic [c_aw-1:0] w_mem_addr;
   logic [6:0]      w_mem_wdata;
   logic [c_aw-1:0] w_rd_idx;
   logic            w_col_ok;
   logic [9:0]      w_sil_inc;

   assign w_tick    = r_vsync_d & ~vsync;
   // din=0x00 gives 128, the only value needing saturation
   assign w_diff    = din[7] ? {1'b0, din[6:0]} : (8'd128 - din);
   assign w_mag     = w_diff[7] ? 7'd127 : w_diff[6:0];
   assign w_col_ok  = ({1'b0, rd_col} < c_nbars);
   assign w_rd_idx  = r_wr_ptr - c_one - rd_col[c_aw-1:0];
   assign w_sil_inc = (r_sil_cnt >= c_hide) ? c_hide : (r_sil_cnt + 10'd1);

   always_ff @(posedge clk_vid or posedge reset) begin
      if (reset) begin
         r_state <= ST_INIT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_mem_we    = 1'b0;
      w_mem_addr  = r_idx;
      w_mem_wdata = 7'd0;
      case (r_state)
         ST_INIT: begin
            w_mem_we = 1'b1;
            if (r_idx == c_last_idx) w_state_nxt = ST_IDLE;
         end
         ST_IDLE: begin
            if (w_tick) w_state_nxt = ST_WRITE;
         end
         ST_WRITE: begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_wr_ptr;
            w_mem_wdata = r_bar;
            w_state_nxt = ST_UPDATE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Buffer has no reset; INIT zeroes it after every reset.
   always_ff @(posedge clk_vid) begin
      if (w_mem_we) r_mem[w_mem_addr] <= w_mem_wdata;
   end

   always_ff @(posedge clk_vid or posedge reset) begin
      if (reset) begin
         r_vsync_d <= 1'b1;
         r_acc     <= 7'd0;
         r_bar     <= 7'd0;
         r_wr_ptr  <= '0;
         r_idx     <= '0;
         r_sil_cnt <= 10'd0;
         r_hidden  <= 1'b1;
         r_ready   <= 1'b0;
         r_rd_data <= 7'd0;
      end else begin
         r_vsync_d <= vsync;
         // A sample coinciding with the committing tick starts the next frame
         if (r_state == ST_IDLE && w_tick) begin
            r_bar <= r_acc;
            r_acc <= sample ? w_mag : 7'd0;
         end else if (sample && (w_mag > r_acc)) begin
            r_acc <= w_mag;
         end
         case (r_state)
            ST_INIT: begin
               r_idx <= r_idx + c_one;
               if (r_idx == c_last_idx) r_ready <= 1'b1;
            end
            ST_WRITE: begin
               r_wr_ptr <= r_wr_ptr + c_one;
            end
            ST_UPDATE: begin
               if (r_bar < c_sil_th) begin
                  r_sil_cnt <= w_sil_inc;
                  if (w_sil_inc == c_hide) r_hidden <= 1'b1;
               end else begin
                  r_sil_cnt <= 10'd0;
                  r_hidden  <= 1'b0;
               end
            end
            default: ;
         endcase
         r_rd_data <= (r_ready && w_col_ok) ? r_mem[w_rd_idx] : 7'd0;
      end
   end

`ifdef PEAK_HOLD_EN
   logic [6:0] r_peak_hold;

   always_ff @(posedge clk_vid or posedge reset) begin
      if (reset) begin
         r_peak_hold <= 7'd0;
      end else if (r_state == ST_UPDATE) begin
         if (r_bar >= r_peak_hold)    r_peak_hold <= r_bar;
         else if (r_peak_hold != 0)   r_peak_hold <= r_peak_hold - 7'd1;
      end
   end

   assign peak_hold = r_peak_hold;
`else
   assign peak_hold = 7'd0;
`endif

   assign rd_data = r_rd_data;
   assign ready   = r_ready;
   assign show    = r_ready & en & (status[2:0] != 3'd0) & ~r_hidden;

endmodule
`default_nettype wire

// File: tb/tb_overlay_bar_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_overlay_bar_sched
//  Description : Self-checking bench for overlay_bar_sched with a read
//                scoreboard and a small reference model of the bar history.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_overlay_bar_sched;
   localparam int NBARS       = 32;
   localparam int SILENCE_TH  = 4;
   localparam int HIDE_FRAMES = 150;

   logic       clk_vid = 1'b0;
   logic       reset   = 1'b1;
   logic [7:0] din     = 8'h80;
   logic       sample  = 1'b0;
   logic       vsync   = 1'b1;
   logic [3:0] status  = 4'd0;
   logic       en      = 1'b0;
   logic [6:0] rd_col  = 7'd0;
   logic [6:0] rd_data;
   logic       show;
   logic       ready;
   logic [6:0] peak_hold;

   int n_pass  = 0;
   int n_total = 0;
   int exp_q[$];
   int hist[$];
   int acc_m   = 0;
   int ph_m    = 0;

   overlay_bar_sched #(
      .NBARS      (NBARS),
      .SILENCE_TH (SILENCE_TH),
      .HIDE_FRAMES(HIDE_FRAMES)
   ) dut (
      .clk_vid  (clk_vid),
      .reset    (reset),
      .din      (din),
      .sample   (sample),
      .vsync    (vsync),
      .status   (status),
      .en       (en),
      .rd_col   (rd_col),
      .rd_data  (rd_data),
      .show     (show),
      .ready    (ready),
      .peak_hold(peak_hold)
   );

   always #5 clk_vid = ~clk_vid;

   function automatic int mag(input int d);
      int m;
      m = (d >= 128) ? d - 128 : 128 - d;
      return (m > 127) ? 127 : m;
   endfunction

   function automatic int exp_col(input int c);
      if (c >= NBARS || c >= hist.size()) return 0;
      return hist[c];
   endfunction

   task automatic model_reset();
      hist.delete();
      acc_m = 0;
      ph_m  = 0;
   endtask

   task automatic model_commit(input int coincident_m);
      hist.push_front(acc_m);
      if (hist.size() > NBARS) void'(hist.pop_back());
      if (acc_m >= ph_m) ph_m = acc_m;
      else if (ph_m > 0) ph_m = ph_m - 1;
      acc_m = coincident_m;
   endtask

   task automatic drive_sample(input int d);
      din    = 8'(d);
      sample = 1'b1;
      if (mag(d) > acc_m) acc_m = mag(d);
      @(negedge clk_vid);
      sample = 1'b0;
   endtask

   // One vsync falling edge, then wait until WRITE and UPDATE have finished
   task automatic frame_tick();
      vsync = 1'b0;
      model_commit(0);
      @(negedge clk_vid);
      vsync = 1'b1;
      repeat (2) @(negedge clk_vid);
   endtask

   task automatic read_col(input int col, output logic [6:0] v);
      rd_col = 7'(col);
      @(negedge clk_vid);
      v = rd_data;
   endtask

   task automatic test_reset();
      logic [6:0] v;
      logic [6:0] e;
      reset = 1'b1;
      model_reset();
      repeat (2) @(negedge clk_vid);
      n_total++;
      if ({ready, show, rd_data, peak_hold} !== 16'd0) $display("FAIL reset_outputs: got ready=%0b show=%0b rd_data=%0d peak_hold=%0d, want all 0", ready, show, rd_data, peak_hold);
      else n_pass++;
      reset = 1'b0;
      for (int k = 1; k <= NBARS; k++) begin
         @(posedge clk_vid);
         #1;
         if (k == 1) begin
            n_total++;
            if (rd_data !== 7'd0) $display("FAIL init_rd_data: got %0d want 0", rd_data);
            else n_pass++;
         end
         if (k == NBARS - 1) begin
            n_total++;
            if (ready !== 1'b0) $display("FAIL ready_early: got ready=%0b at cycle %0d want 0", ready, k);
            else n_pass++;
         end
         if (k == NBARS) begin
            n_total++;
            if (ready !== 1'b1) $display("FAIL ready_rise: got ready=%0b at cycle %0d want 1", ready, k);
            else n_pass++;
         end
      end
      @(negedge clk_vid);
      for (int c = 0; c <= NBARS; c++) begin
         exp_q.push_back(exp_col(c));
         read_col(c, v);
         e = 7'(exp_q.pop_front());
         n_total++;
         if (v !== e) $display("FAIL reset_read col=%0d: got %0d want %0d", c, v, e);
         else n_pass++;
      end
      n_total++;
      if (show !== 1'b0) $display("FAIL reset_show: got %0b want 0", show);
      else n_pass++;
   endtask

   task automatic test_basic();
      logic [6:0] v;
      logic [6:0] e;
      drive_sample(8'h90);
      drive_sample(8'h70);
      drive_sample(8'hFF);
      frame_tick();
      exp_q.push_back(127);
      read_col(0, v);
      e = 7'(exp_q.pop_front());
      n_total++;
      if (v !== e) $display("FAIL basic_first col=0: got %0d want %0d", v, e);
      else n_pass++;
      drive_sample(8'h88);
      frame_tick();
      exp_q.push_back(8);
      exp_q.push_back(127);
      for (int c = 0; c < 2; c++) begin
         read_col(c, v);
         e = 7'(exp_q.pop_front());
         n_total++;
         if (v !== e) $display("FAIL basic_second col=%0d: got %0d want %0d", c, v, e);
         else n_pass++;
      end
   endtask

   task automatic test_wrap();
      logic [6:0] v;
      logic [6:0] e;
      for (int i = 0; i < NBARS + 3; i++) begin
         drive_sample(128 + i + 1);
         frame_tick();
      end
      for (int c = 0; c <= NBARS; c++) begin
         exp_q.push_back(exp_col(c));
         read_col(c, v);
         e = 7'(exp_q.pop_front());
         n_total++;
         if (v !== e) $display("FAIL wrap_read col=%0d: got %0d want %0d", c, v, e);
         else n_pass++;
      end
   endtask

   task automatic test_hide();
      en     = 1'b1;
      status = 4'd1;
      drive_sample(8'hFF);
      frame_tick();
      n_total++;
      if (show !== 1'b1) $display("FAIL hide_loud: got show=%0b want 1", show);
      else n_pass++;
      for (int k = 1; k <= HIDE_FRAMES; k++) begin
         frame_tick();
         if (k == HIDE_FRAMES - 1) begin
            n_total++;
            if (show !== 1'b1) $display("FAIL hide_early: got show=%0b after %0d silent frames want 1", show, k);
            else n_pass++;
         end
         if (k == HIDE_FRAMES) begin
            n_total++;
            if (show !== 1'b0) $display("FAIL hide_drop: got show=%0b after %0d silent frames want 0", show, k);
            else n_pass++;
         end
      end
      drive_sample(8'h8A);
      frame_tick();
      n_total++;
      if (show !== 1'b1) $display("FAIL hide_recover: got show=%0b want 1", show);
      else n_pass++;
      en = 1'b0;
      #1;
      n_total++;
      if (show !== 1'b0) $display("FAIL show_en_off: got show=%0b want 0", show);
      else n_pass++;
      en = 1'b1;
      status = 4'd8;
      #1;
      n_total++;
      if (show !== 1'b0) $display("FAIL show_status3_only: got show=%0b want 0", show);
      else n_pass++;
      status = 4'd1;
   endtask

   task automatic test_coincident();
      logic [6:0] v;
      logic [6:0] e;
      drive_sample(8'h90);
      din    = 8'hC0;
      sample = 1'b1;
      vsync  = 1'b0;
      model_commit(mag(8'hC0));
      @(negedge clk_vid);
      sample = 1'b0;
      vsync  = 1'b1;
      @(negedge clk_vid);
      vsync  = 1'b0;
      @(negedge clk_vid);
      vsync  = 1'b1;
      @(negedge clk_vid);
      exp_q.push_back(16);
      exp_q.push_back(exp_col(1));
      for (int c = 0; c < 2; c++) begin
         read_col(c, v);
         e = 7'(exp_q.pop_front());
         n_total++;
         if (v !== e) $display("FAIL coincident_commit col=%0d: got %0d want %0d", c, v, e);
         else n_pass++;
      end
      frame_tick();
      exp_q.push_back(64);
      exp_q.push_back(16);
      exp_q.push_back(exp_col(2));
      for (int c = 0; c < 3; c++) begin
         read_col(c, v);
         e = 7'(exp_q.pop_front());
         n_total++;
         if (v !== e) $display("FAIL dropped_tick col=%0d: got %0d want %0d", c, v, e);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_init();
      logic [6:0] v;
      logic [6:0] e;
      reset = 1'b1;
      model_reset();
      @(negedge clk_vid);
      reset = 1'b0;
      repeat (5) @(negedge clk_vid);
      reset = 1'b1;
      #1;
      n_total++;
      if (ready !== 1'b0) $display("FAIL mid_init_ready: got %0b want 0", ready);
      else n_pass++;
      @(negedge clk_vid);
      reset = 1'b0;
      for (int k = 1; k <= NBARS; k++) begin
         @(posedge clk_vid);
         #1;
         if (k == NBARS - 1) begin
            n_total++;
            if (ready !== 1'b0) $display("FAIL mid_init_ready_early: got %0b at cycle %0d want 0", ready, k);
            else n_pass++;
         end
         if (k == NBARS) begin
            n_total++;
            if (ready !== 1'b1) $display("FAIL mid_init_ready_rise: got %0b at cycle %0d want 1", ready, k);
            else n_pass++;
         end
      end
      @(negedge clk_vid);
      n_total++;
      if (show !== 1'b0) $display("FAIL reset_hidden: got show=%0b want 0", show);
      else n_pass++;
      for (int c = 0; c < NBARS; c++) begin
         exp_q.push_back(exp_col(c));
         read_col(c, v);
         e = 7'(exp_q.pop_front());
         n_total++;
         if (v !== e) $display("FAIL rezero col=%0d: got %0d want %0d", c, v, e);
         else n_pass++;
      end
   endtask

   task automatic test_peak_hold();
      int bars[3] = '{100, 20, 20};
      logic [6:0] e;
      logic [6:0] v;
      for (int i = 0; i < 3; i++) begin
         drive_sample(128 + bars[i]);
         frame_tick();
`ifdef PEAK_HOLD_EN
         exp_q.push_back(ph_m);
`else
         exp_q.push_back(0);
`endif
         e = 7'(exp_q.pop_front());
         n_total++;
         if (peak_hold !== e) $display("FAIL peak_hold step=%0d: got %0d want %0d", i, peak_hold, e);
         else n_pass++;
      end
      for (int c = 0; c < 3; c++) begin
         exp_q.push_back(exp_col(c));
         read_col(c, v);
         e = 7'(exp_q.pop_front());
         n_total++;
         if (v !== e) $display("FAIL peak_bars col=%0d: got %0d want %0d", c, v, e);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_hide();
      test_coincident();
      test_reset_mid_init();
      test_peak_hold();
      if (exp_q.size() != 0) begin
         n_total++;
         $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
